// File: rtl/systolic_array_stream_pkg.sv
// systolic_pkg: shared FSM state type and arithmetic helpers for the systolic array
package systolic_pkg;
    typedef enum logic [1:0] {EMPTY, LOAD, RUN, DRAIN} state_t;

    function automatic int acc_width(int bits, int wbits, int n);
        return bits + wbits + $clog2(n) + 1;
    endfunction

    function automatic logic signed [63:0] sat(logic signed [63:0] v, int bits);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction
endpackage

// File: rtl/systolic_array_stream_skew_line.sv
// skew_line: enable-gated shift register of Depth stages (Depth >= 1)
module skew_line #(
    parameter int Width = 8,
    parameter int Depth = 1
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             i_en,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);
    logic [Width-1:0] r_sh [Depth];

    // shift one stage per enabled cycle, cleared on reset
    always_ff @(posedge clk) begin
        if (!res_n) begin
            for (int i = 0; i < Depth; i++) r_sh[i] <= '0;
        end else if (i_en) begin
            r_sh[0] <= i_d;
            for (int i = 1; i < Depth; i++) r_sh[i] <= r_sh[i-1];
        end
    end

    assign o_q = r_sh[Depth-1];
endmodule

// File: rtl/systolic_array_stream.sv
// systolic_array_stream: weight-stationary systolic array with skew/de-skew, bias, saturation and backpressure
module systolic_array_stream
    import systolic_pkg::*;
#(
    parameter int BitSize        = 8,
    parameter int Weight_BitSize = 4,
    parameter int NumOfInputs    = 4,
    parameter int NumOfNerves    = 4
) (
    input  logic                                clk,
    input  logic                                res_n,
    input  logic                                in_w_valid,
    input  logic [NumOfNerves*Weight_BitSize-1:0] in_weights,
    input  logic [NumOfNerves*BitSize-1:0]      in_bias,
    output logic                                out_w_ready,
    input  logic                                in_valid,
    input  logic                                in_last,
    input  logic [NumOfInputs*BitSize-1:0]      in_data,
    output logic                                in_ready,
    output logic                                out_valid,
    output logic                                out_last,
    output logic [NumOfNerves*BitSize-1:0]      out_data,
    input  logic                                in_out_ready
);
    localparam int AccW = acc_width(BitSize, Weight_BitSize, NumOfInputs);
    localparam int Lat  = NumOfInputs + NumOfNerves;
    localparam int CntW = $clog2(Lat + 2) + 1;
    localparam int WcW  = (NumOfInputs > 1) ? $clog2(NumOfInputs) : 1;

    state_t                           r_state;
    logic [WcW-1:0]                   r_wcnt;
    logic [CntW-1:0]                  r_inflight;
    logic signed [Weight_BitSize-1:0] r_w [NumOfInputs][NumOfNerves];
    logic signed [BitSize-1:0]        r_bias [NumOfNerves];
    logic [NumOfInputs*BitSize-1:0]   r_in;
    logic signed [BitSize-1:0]        r_a [NumOfInputs][NumOfNerves];
    logic signed [AccW-1:0]           r_ps [NumOfInputs][NumOfNerves];
    logic [NumOfNerves*BitSize-1:0]   r_out;
    logic signed [BitSize-1:0]        w_skew [NumOfInputs];
    logic signed [AccW-1:0]           w_col [NumOfNerves];
    logic [1:0]                       w_vq;
    logic                             w_adv;
    logic                             w_acc;
    logic                             w_done;

    assign w_adv       = !out_valid || in_out_ready;
    assign in_ready    = (r_state == RUN) && w_adv;
    assign w_acc       = in_valid && in_ready;
    assign w_done      = out_valid && in_out_ready;
    assign out_w_ready = (r_state == EMPTY) || (r_state == LOAD);
    assign out_valid   = w_vq[0];
    assign out_last    = w_vq[1];
    assign out_data    = r_out;

    // weight-load FSM: direct row writes, bias with row 0, drain before reload
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_state <= EMPTY;
            r_wcnt  <= '0;
            for (int k = 0; k < NumOfInputs; k++)
                for (int j = 0; j < NumOfNerves; j++) r_w[k][j] <= '0;
            for (int j = 0; j < NumOfNerves; j++) r_bias[j] <= '0;
        end else begin
            case (r_state)
                EMPTY, LOAD: if (in_w_valid) begin
                    for (int j = 0; j < NumOfNerves; j++)
                        r_w[r_wcnt][j] <= in_weights[j*Weight_BitSize +: Weight_BitSize];
                    if (r_wcnt == '0)
                        for (int j = 0; j < NumOfNerves; j++) r_bias[j] <= in_bias[j*BitSize +: BitSize];
                    r_wcnt  <= (r_wcnt == WcW'(NumOfInputs - 1)) ? '0 : r_wcnt + 1'b1;
                    r_state <= (r_wcnt == WcW'(NumOfInputs - 1)) ? RUN : LOAD;
                end
                RUN: if (in_w_valid) r_state <= DRAIN;
                DRAIN: if (r_inflight == '0 && !out_valid) begin
                    r_state <= LOAD;
                    r_wcnt  <= '0;
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    // rows accepted but not yet handed downstream
    always_ff @(posedge clk) begin
        if (!res_n) r_inflight <= '0;
        else r_inflight <= r_inflight + CntW'(w_acc) - CntW'(w_done);
    end

    // input stage: bubbles enter as zero data
    always_ff @(posedge clk) begin
        if (!res_n) r_in <= '0;
        else if (w_adv) r_in <= w_acc ? in_data : '0;
    end

    genvar k, j;
    generate
        for (k = 0; k < NumOfInputs; k++) begin : g_row
            if (k == 0) begin : g_nodly
                assign w_skew[k] = r_in[k*BitSize +: BitSize];
            end else begin : g_dly
                skew_line #(.Width(BitSize), .Depth(k)) u_skew (
                    .clk(clk), .res_n(res_n), .i_en(w_adv),
                    .i_d(r_in[k*BitSize +: BitSize]), .o_q(w_skew[k])
                );
            end
            for (j = 0; j < NumOfNerves; j++) begin : g_pe
                logic signed [BitSize-1:0] w_ain;
                logic signed [AccW-1:0]    w_pin;
                if (j == 0) begin : g_al
                    assign w_ain = w_skew[k];
                end else begin : g_ar
                    assign w_ain = r_a[k][j-1];
                end
                if (k == 0) begin : g_pt
                    assign w_pin = AccW'(r_bias[j]);
                end else begin : g_pb
                    assign w_pin = r_ps[k-1][j];
                end
                // PE: pass activation right, accumulate partial sum downward
                always_ff @(posedge clk) begin
                    if (!res_n) begin
                        r_a[k][j]  <= '0;
                        r_ps[k][j] <= '0;
                    end else if (w_adv) begin
                        r_a[k][j]  <= w_ain;
                        r_ps[k][j] <= w_pin + AccW'(w_ain) * AccW'(r_w[k][j]);
                    end
                end
            end
        end
        for (j = 0; j < NumOfNerves; j++) begin : g_col
            if (j == NumOfNerves - 1) begin : g_nodly
                assign w_col[j] = r_ps[NumOfInputs-1][j];
            end else begin : g_dly
                skew_line #(.Width(AccW), .Depth(NumOfNerves - 1 - j)) u_deskew (
                    .clk(clk), .res_n(res_n), .i_en(w_adv),
                    .i_d(r_ps[NumOfInputs-1][j]), .o_q(w_col[j])
                );
            end
        end
    endgenerate

    skew_line #(.Width(2), .Depth(Lat + 1)) u_vld (
        .clk(clk), .res_n(res_n), .i_en(w_adv),
        .i_d({w_acc && in_last, w_acc}), .o_q(w_vq)
    );

    // output register: saturate each aligned column once
    always_ff @(posedge clk) begin
        if (!res_n) r_out <= '0;
        else if (w_adv)
            for (int n = 0; n < NumOfNerves; n++)
                r_out[n*BitSize +: BitSize] <= BitSize'(sat(64'(w_col[n]), BitSize));
    end
endmodule

// File: tb/tb_systolic_array_stream.sv
// tb_systolic_array_stream: directed and random stimulus against a row-level arithmetic model
module tb_systolic_array_stream;
    localparam int B = 8, WB = 4, NI = 2, NN = 2;

    logic clk = 0, res_n = 0, in_w_valid = 0, in_valid = 0, in_last = 0, in_out_ready = 1;
    logic [NN*WB-1:0] in_weights = '0;
    logic [NN*B-1:0]  in_bias = '0;
    logic [NI*B-1:0]  in_data = '0;
    logic out_w_ready, in_ready, out_valid, out_last;
    logic [NN*B-1:0] out_data;

    always #5 clk = ~clk;

    systolic_array_stream #(.BitSize(B), .Weight_BitSize(WB), .NumOfInputs(NI), .NumOfNerves(NN)) dut (
        .clk(clk), .res_n(res_n), .in_w_valid(in_w_valid), .in_weights(in_weights), .in_bias(in_bias),
        .out_w_ready(out_w_ready), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_last(out_last), .out_data(out_data),
        .in_out_ready(in_out_ready)
    );

    typedef struct {logic [NN*B-1:0] data; logic last; int acc;} exp_t;
    exp_t q[$];
    int total = 0, bad = 0, ncyc = 0, npop = 0, p;
    int mw[NI][NN];
    int mb[NN];
    bit w_hs, i_hs, chk_lat, hold_chk;
    logic [NN*B-1:0] hold_val;

    function automatic logic [NN*B-1:0] model(logic [NI*B-1:0] d);
        logic [NN*B-1:0] r;
        int s;
        for (int j = 0; j < NN; j++) begin
            s = mb[j];
            for (int k = 0; k < NI; k++) s += int'($signed(d[k*B +: B])) * mw[k][j];
            if (s > (1 << (B-1)) - 1) s = (1 << (B-1)) - 1;
            if (s < -(1 << (B-1))) s = -(1 << (B-1));
            r[j*B +: B] = B'(s);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic cyc();
        exp_t e;
        @(negedge clk);
        w_hs = in_w_valid && out_w_ready;
        i_hs = in_valid && in_ready;
        if (out_w_ready) chk("wready_with_rows_in_flight", q.size(), 0);
        if (hold_chk) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, hold_val);
            chk("stall_in_ready", in_ready, 0);
        end
        if (out_valid && in_out_ready) begin
            if (q.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
                e = q.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_last", out_last, e.last);
                if (chk_lat) chk("latency", ncyc - 1 - e.acc, 4);
                npop++;
            end
        end
        if (i_hs) q.push_back('{model(in_data), in_last, ncyc});
        @(posedge clk);
        ncyc++;
        #2;
    endtask

    task automatic load_row(input logic [NN*WB-1:0] w, input logic [NN*B-1:0] b);
        bit done = 0;
        in_w_valid = 1; in_weights = w; in_bias = b;
        for (int t = 0; t < 40 && !done; t++) begin cyc(); done = w_hs; end
        in_w_valid = 0;
        chk("wload_timeout", done, 1);
    endtask

    task automatic load_w(input int w00, w01, w10, w11, b0, b1);
        load_row({WB'(w01), WB'(w00)}, {B'(b1), B'(b0)});
        load_row({WB'(w11), WB'(w10)}, {B'(b1), B'(b0)});
        mw[0][0] = w00; mw[0][1] = w01; mw[1][0] = w10; mw[1][1] = w11;
        mb[0] = b0; mb[1] = b1;
    endtask

    task automatic send(input logic [B-1:0] a0, a1, input logic last);
        bit done = 0;
        in_valid = 1; in_data = {a1, a0}; in_last = last;
        for (int t = 0; t < 40 && !done; t++) begin cyc(); done = i_hs; end
        in_valid = 0; in_last = 0;
        chk("send_timeout", done, 1);
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && q.size() != 0; t++) cyc();
        chk("drain_empty", q.size(), 0);
        repeat (3) cyc();
    endtask

    initial begin
        repeat (2) cyc();
        res_n = 1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_w_ready", out_w_ready, 1);
        load_w(1, 2, 3, -1, 0, 5);
        chk_lat = 1;
        p = npop;
        send(8'd4, 8'd5, 0);
        for (int t = 0; t < 20 && npop == p; t++) cyc();
        chk("s1_popped", npop, p + 1);
        chk("s1_one_cycle", out_valid, 0);
        send(8'd1, 8'd0, 0); send(8'd0, 8'd1, 0); send(8'd2, 8'd2, 1);
        drain();
        chk_lat = 0;
        send(8'd1, 8'd0, 0); send(8'd0, 8'd1, 0); send(8'd2, 8'd2, 1);
        p = npop;
        for (int t = 0; t < 20 && npop == p; t++) cyc();
        in_out_ready = 0;
        hold_val = q[0].data;
        hold_chk = 1;
        in_valid = 1; in_data = {8'd1, 8'd1}; in_last = 1;
        repeat (3) cyc();
        hold_chk = 0;
        in_out_ready = 1;
        send(8'd1, 8'd1, 1);
        drain();
        load_w(7, 7, 7, 7, 0, 0);
        send(8'd127, 8'd127, 0); send(8'h80, 8'h80, 1);
        drain();
        load_w(1, 2, 3, -1, 0, 5);
        send(8'd4, 8'd5, 0);
        in_w_valid = 1; in_weights = {4'd0, 4'd1}; in_bias = '0;
        send(8'd1, 8'd1, 0);
        load_w(1, 0, 0, 1, 0, 0);
        send(8'd9, 8'hFD, 1);
        drain();
        send(8'd4, 8'd5, 0); send(8'd1, 8'd1, 0);
        res_n = 0;
        cyc();
        q.delete();
        res_n = 1;
        chk("r6_out_valid", out_valid, 0);
        chk("r6_out_last", out_last, 0);
        chk("r6_out_data", out_data, 0);
        chk("r6_out_w_ready", out_w_ready, 1);
        in_valid = 1; in_data = {8'd5, 8'd4};
        for (int t = 0; t < 3; t++) begin cyc(); chk("r6_in_ready_empty", in_ready, 0); end
        load_row({4'd2, 4'd1}, {8'd5, 8'd0});
        chk("r6_in_ready_partial", in_ready, 0);
        mw[0][0] = 1; mw[0][1] = 2; mw[1][0] = 3; mw[1][1] = -1; mb[0] = 0; mb[1] = 5;
        load_row({4'hF, 4'd3}, {8'd5, 8'd0});
        chk("r6_in_ready_loaded", in_ready, 1);
        send(8'd4, 8'd5, 1);
        drain();
        for (int r = 0; r < 2; r++) begin
            load_w(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                   int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                   int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
            for (int i = 0; i < 150; i++) begin
                in_valid = $urandom_range(0, 3) != 0;
                in_data = NI*B'($urandom);
                in_last = 1'($urandom);
                in_out_ready = $urandom_range(0, 3) != 0;
                cyc();
            end
            in_valid = 0; in_last = 0; in_out_ready = 1;
            drain();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/systolic_array_stream.md
# systolic_array_stream

Parametrised successor to the layer matrix-multiply engine: an `NumOfInputs` x `NumOfNerves` weight-stationary systolic array with internal input skew and output de-skew, so upstream presents whole input rows and downstream receives whole output rows. It adds:

- a weight-load FSM that supports reloading between batches;
- per-nerve bias;
- saturating signed arithmetic;
- full valid/ready backpressure.

It sits between consecutive layer stages in the CNN datapath.

## Interface
Parameters:
- `BitSize`, 8, signed data/activation width (inputs, bias, outputs)
- `Weight_BitSize`, 4, signed weight width
- `NumOfInputs`, 4, array rows (inputs per output)
- `NumOfNerves`, 4, array columns (nerves in layer)

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  rising-edge clock
- `res_n`  in  1  synchronous active-low reset
- `in_w_valid`  in  1  weight row offered
- `in_weights`  in  `NumOfNerves*Weight_BitSize`  weight row k; nerve j at `[j*Weight_BitSize +: Weight_BitSize]`
- `in_bias`  in  `NumOfNerves*BitSize`  per-nerve bias; sampled with weight row 0
- `out_w_ready`  out  1  array accepts weight rows
- `in_valid`  in  1  input row offered
- `in_last`  in  1  last row of batch, travels with the row
- `in_data`  in  `NumOfInputs*BitSize`  input k at `[k*BitSize +: BitSize]`
- `in_ready`  out  1  input row accepted when `in_valid && in_ready`
- `out_valid`  out  1  output row present
- `out_last`  out  1  tag of the row on `out_data`
- `out_data`  out  `NumOfNerves*BitSize`  nerve j at `[j*BitSize +: BitSize]`
- `in_out_ready`  in  1  downstream accepts the output row

## Operation
- FSM states `EMPTY`, `LOAD`, `RUN`, `DRAIN`. Reset enters `EMPTY` and invalidates the weights.
- `out_w_ready` = state is `EMPTY` or `LOAD`.
- `EMPTY`: the first accepted weight row goes to row 0. Bias is latched at the same time. The FSM moves to `LOAD`.
- `LOAD`: each accepted row is written to row index `w_cnt`, and `w_cnt` increments. After row `NumOfInputs-1` the FSM moves to `RUN`. Rows are written directly into the register array, not shifted.
- `RUN`: `in_ready` = `advance`, where `advance` = `!out_valid || in_out_ready`.
  - The whole pipeline (skew, PEs, de-skew, valid/last shift chain) moves only on `advance`.
  - On `advance` with no accepted input, a bubble (valid = 0) enters the pipeline.
- `in_w_valid` seen in `RUN`: the FSM moves to `DRAIN`. `in_ready` = 0. The pipeline keeps advancing bubbles until no valid row is in flight and `out_valid` = 0, then the FSM moves to `LOAD` with `w_cnt` = 0.
- Arithmetic:
  - `out[j]` = `sat_BitSize(bias[j] + sum_k in[k]*w[k][j])`, all operands signed.
  - Accumulator width = `BitSize + Weight_BitSize + clog2(NumOfInputs) + 1`, so no internal overflow occurs.
  - Saturation happens once, at the output: range [-2^(BitSize-1), 2^(BitSize-1)-1].
- Row order is preserved. Rows are never dropped or duplicated under any stall pattern.

## Timing
- Latency L = `NumOfInputs + NumOfNerves` advance cycles from input acceptance to `out_valid`. With no stalls this is L clock cycles.
- Throughput: 1 row per cycle while `in_out_ready` = 1.
- All nerves of one row appear on `out_data` in the same cycle, held stable while `out_valid && !in_out_ready`.
- Reset values: `out_valid` 0, `out_last` 0, `out_data` 0, `in_ready` 0, `out_w_ready` 1 (state `EMPTY`). All pipeline registers are cleared.
- Reset mid-operation: in-flight rows are discarded and weights are invalidated. A full reload is required before `in_ready` rises.
- Input offered in `EMPTY`/`LOAD`/`DRAIN`: not accepted (`in_ready` = 0).
- `in_w_valid` and `in_valid` high together in `RUN`: the input row is accepted if `advance`, then the FSM enters `DRAIN`. That row still completes with the old weights.
- `in_w_valid` low during `LOAD`: the FSM waits; a partial load is not usable.

## Structure
- Package `systolic_pkg`: `state_t` enum, the accumulator-width function, and the saturation function.
- Sub-module `skew_line #(Width, Depth)`: an enable-gated shift register. It is used for the input skew (row k delay k), the output de-skew (column j delay `NumOfNerves-1-j`), and the valid/last chain.
- PEs are inline registers in a generate loop: stationary weight, `a` pass-right, partial-sum pass-down, all gated by `advance`.

## Test plan
Common setup: `NumOfInputs`=2, `NumOfNerves`=2, `BitSize`=8, `Weight_BitSize`=4, with W row0 = [1,2], row1 = [3,-1] and bias = [0,5] unless a scenario states otherwise.

1. Basic row: input [4,5] -> `out_data` = [19,8] exactly 4 cycles after acceptance; `out_valid` high 1 cycle.
2. Streaming: inputs [1,0], [0,1], [2,2] back-to-back with `in_last` on the third -> outputs [1,7], [3,4], [8,7] on consecutive cycles; `out_last` on the third only.
3. Backpressure: same stream as scenario 2 with `in_out_ready` low for 3 cycles mid-stream -> `out_data` held stable during the stall, `in_ready` low during the stall, no loss, same order.
4. Saturation: W all 7, bias 0.
   - Input [127,127] -> output [127,127].
   - Input [-128,-128] -> output [-128,-128].
5. Reload: assert `in_w_valid` while 2 rows are in flight -> both rows complete with the old W, then `out_w_ready` rises. New W = identity -> input [9,-3] gives output [9,-3].
6. Reset mid-stream: `res_n` low 1 cycle with rows in flight -> every output at its reset value, `in_ready` stays 0 until 2 weight rows are reloaded.
